// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared constants, FSM state type and round-function helpers
//               for the iterative AES-128 encryption core.
//               Byte order everywhere: bits [127:120] hold byte 0 (s0,0),
//               column-major, so column c is bits [127-32c -: 32].
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    // Number of rounds for AES-128; the key schedule supports only this value.
    localparam int AES128_NR = 10;

    // Round constants rcon[1..10], rcon[1] in the most significant byte.
    localparam logic [79:0] c_rcon_table = 80'h01_02_04_08_10_20_40_80_1b_36;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } aes_fsm_t;

    // Round constant for round 1..10; any other round number yields zero.
    function automatic logic [7:0] rcon_byte(input logic [3:0] round);
        int idx;
        rcon_byte = 8'h00;
        if (round >= 4'd1 && round <= 4'd10) begin
            idx = 10 - int'(round);
            rcon_byte = c_rcon_table[8*idx +: 8];
        end
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column; row 0 byte sits in bits [31:24].
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        mix_column[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        mix_column[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        mix_column[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        mix_column[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    endfunction

    // Row r is rotated left by r positions: out(r,c) = in(r,(c+r) mod 4).
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        shift_rows = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shift_rows[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational AES forward S-box (256-entry lookup table).
// Ports       : i_byte - input byte
//               o_byte - substituted byte
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    always_comb begin
        o_byte = 8'h00;
        case (i_byte)
            8'h00: o_byte = 8'h63; 8'h01: o_byte = 8'h7c; 8'h02: o_byte = 8'h77; 8'h03: o_byte = 8'h7b; 8'h04: o_byte = 8'hf2; 8'h05: o_byte = 8'h6b; 8'h06: o_byte = 8'h6f; 8'h07: o_byte = 8'hc5;
            8'h08: o_byte = 8'h30; 8'h09: o_byte = 8'h01; 8'h0a: o_byte = 8'h67; 8'h0b: o_byte = 8'h2b; 8'h0c: o_byte = 8'hfe; 8'h0d: o_byte = 8'hd7; 8'h0e: o_byte = 8'hab; 8'h0f: o_byte = 8'h76;
            8'h10: o_byte = 8'hca; 8'h11: o_byte = 8'h82; 8'h12: o_byte = 8'hc9; 8'h13: o_byte = 8'h7d; 8'h14: o_byte = 8'hfa; 8'h15: o_byte = 8'h59; 8'h16: o_byte = 8'h47; 8'h17: o_byte = 8'hf0;
            8'h18: o_byte = 8'had; 8'h19: o_byte = 8'hd4; 8'h1a: o_byte = 8'ha2; 8'h1b: o_byte = 8'haf; 8'h1c: o_byte = 8'h9c; 8'h1d: o_byte = 8'ha4; 8'h1e: o_byte = 8'h72; 8'h1f: o_byte = 8'hc0;
            8'h20: o_byte = 8'hb7; 8'h21: o_byte = 8'hfd; 8'h22: o_byte = 8'h93; 8'h23: o_byte = 8'h26; 8'h24: o_byte = 8'h36; 8'h25: o_byte = 8'h3f; 8'h26: o_byte = 8'hf7; 8'h27: o_byte = 8'hcc;
            8'h28: o_byte = 8'h34; 8'h29: o_byte = 8'ha5; 8'h2a: o_byte = 8'he5; 8'h2b: o_byte = 8'hf1; 8'h2c: o_byte = 8'h71; 8'h2d: o_byte = 8'hd8; 8'h2e: o_byte = 8'h31; 8'h2f: o_byte = 8'h15;
            8'h30: o_byte = 8'h04; 8'h31: o_byte = 8'hc7; 8'h32: o_byte = 8'h23; 8'h33: o_byte = 8'hc3; 8'h34: o_byte = 8'h18; 8'h35: o_byte = 8'h96; 8'h36: o_byte = 8'h05; 8'h37: o_byte = 8'h9a;
            8'h38: o_byte = 8'h07; 8'h39: o_byte = 8'h12; 8'h3a: o_byte = 8'h80; 8'h3b: o_byte = 8'he2; 8'h3c: o_byte = 8'heb; 8'h3d: o_byte = 8'h27; 8'h3e: o_byte = 8'hb2; 8'h3f: o_byte = 8'h75;
            8'h40: o_byte = 8'h09; 8'h41: o_byte = 8'h83; 8'h42: o_byte = 8'h2c; 8'h43: o_byte = 8'h1a; 8'h44: o_byte = 8'h1b; 8'h45: o_byte = 8'h6e; 8'h46: o_byte = 8'h5a; 8'h47: o_byte = 8'ha0;
            8'h48: o_byte = 8'h52; 8'h49: o_byte = 8'h3b; 8'h4a: o_byte = 8'hd6; 8'h4b: o_byte = 8'hb3; 8'h4c: o_byte = 8'h29; 8'h4d: o_byte = 8'he3; 8'h4e: o_byte = 8'h2f; 8'h4f: o_byte = 8'h84;
            8'h50: o_byte = 8'h53; 8'h51: o_byte = 8'hd1; 8'h52: o_byte = 8'h00; 8'h53: o_byte = 8'hed; 8'h54: o_byte = 8'h20; 8'h55: o_byte = 8'hfc; 8'h56: o_byte = 8'hb1; 8'h57: o_byte = 8'h5b;
            8'h58: o_byte = 8'h6a; 8'h59: o_byte = 8'hcb; 8'h5a: o_byte = 8'hbe; 8'h5b: o_byte = 8'h39; 8'h5c: o_byte = 8'h4a; 8'h5d: o_byte = 8'h4c; 8'h5e: o_byte = 8'h58; 8'h5f: o_byte = 8'hcf;
            8'h60: o_byte = 8'hd0; 8'h61: o_byte = 8'hef; 8'h62: o_byte = 8'haa; 8'h63: o_byte = 8'hfb; 8'h64: o_byte = 8'h43; 8'h65: o_byte = 8'h4d; 8'h66: o_byte = 8'h33; 8'h67: o_byte = 8'h85;
            8'h68: o_byte = 8'h45; 8'h69: o_byte = 8'hf9; 8'h6a: o_byte = 8'h02; 8'h6b: o_byte = 8'h7f; 8'h6c: o_byte = 8'h50; 8'h6d: o_byte = 8'h3c; 8'h6e: o_byte = 8'h9f; 8'h6f: o_byte = 8'ha8;
            8'h70: o_byte = 8'h51; 8'h71: o_byte = 8'ha3; 8'h72: o_byte = 8'h40; 8'h73: o_byte = 8'h8f; 8'h74: o_byte = 8'h92; 8'h75: o_byte = 8'h9d; 8'h76: o_byte = 8'h38; 8'h77: o_byte = 8'hf5;
            8'h78: o_byte = 8'hbc; 8'h79: o_byte = 8'hb6; 8'h7a: o_byte = 8'hda; 8'h7b: o_byte = 8'h21; 8'h7c: o_byte = 8'h10; 8'h7d: o_byte = 8'hff; 8'h7e: o_byte = 8'hf3; 8'h7f: o_byte = 8'hd2;
            8'h80: o_byte = 8'hcd; 8'h81: o_byte = 8'h0c; 8'h82: o_byte = 8'h13; 8'h83: o_byte = 8'hec; 8'h84: o_byte = 8'h5f; 8'h85: o_byte = 8'h97; 8'h86: o_byte = 8'h44; 8'h87: o_byte = 8'h17;
            8'h88: o_byte = 8'hc4; 8'h89: o_byte = 8'ha7; 8'h8a: o_byte = 8'h7e; 8'h8b: o_byte = 8'h3d; 8'h8c: o_byte = 8'h64; 8'h8d: o_byte = 8'h5d; 8'h8e: o_byte = 8'h19; 8'h8f: o_byte = 8'h73;
            8'h90: o_byte = 8'h60; 8'h91: o_byte = 8'h81; 8'h92: o_byte = 8'h4f; 8'h93: o_byte = 8'hdc; 8'h94: o_byte = 8'h22; 8'h95: o_byte = 8'h2a; 8'h96: o_byte = 8'h90; 8'h97: o_byte = 8'h88;
            8'h98: o_byte = 8'h46; 8'h99: o_byte = 8'hee; 8'h9a: o_byte = 8'hb8; 8'h9b: o_byte = 8'h14; 8'h9c: o_byte = 8'hde; 8'h9d: o_byte = 8'h5e; 8'h9e: o_byte = 8'h0b; 8'h9f: o_byte = 8'hdb;
            8'ha0: o_byte = 8'he0; 8'ha1: o_byte = 8'h32; 8'ha2: o_byte = 8'h3a; 8'ha3: o_byte = 8'h0a; 8'ha4: o_byte = 8'h49; 8'ha5: o_byte = 8'h06; 8'ha6: o_byte = 8'h24; 8'ha7: o_byte = 8'h5c;
            8'ha8: o_byte = 8'hc2; 8'ha9: o_byte = 8'hd3; 8'haa: o_byte = 8'hac; 8'hab: o_byte = 8'h62; 8'hac: o_byte = 8'h91; 8'had: o_byte = 8'h95; 8'hae: o_byte = 8'he4; 8'haf: o_byte = 8'h79;
            8'hb0: o_byte = 8'he7; 8'hb1: o_byte = 8'hc8; 8'hb2: o_byte = 8'h37; 8'hb3: o_byte = 8'h6d; 8'hb4: o_byte = 8'h8d; 8'hb5: o_byte = 8'hd5; 8'hb6: o_byte = 8'h4e; 8'hb7: o_byte = 8'ha9;
            8'hb8: o_byte = 8'h6c; 8'hb9: o_byte = 8'h56; 8'hba: o_byte = 8'hf4; 8'hbb: o_byte = 8'hea; 8'hbc: o_byte = 8'h65; 8'hbd: o_byte = 8'h7a; 8'hbe: o_byte = 8'hae; 8'hbf: o_byte = 8'h08;
            8'hc0: o_byte = 8'hba; 8'hc1: o_byte = 8'h78; 8'hc2: o_byte = 8'h25; 8'hc3: o_byte = 8'h2e; 8'hc4: o_byte = 8'h1c; 8'hc5: o_byte = 8'ha6; 8'hc6: o_byte = 8'hb4; 8'hc7: o_byte = 8'hc6;
            8'hc8: o_byte = 8'he8; 8'hc9: o_byte = 8'hdd; 8'hca: o_byte = 8'h74; 8'hcb: o_byte = 8'h1f; 8'hcc: o_byte = 8'h4b; 8'hcd: o_byte = 8'hbd; 8'hce: o_byte = 8'h8b; 8'hcf: o_byte = 8'h8a;
            8'hd0: o_byte = 8'h70; 8'hd1: o_byte = 8'h3e; 8'hd2: o_byte = 8'hb5; 8'hd3: o_byte = 8'h66; 8'hd4: o_byte = 8'h48; 8'hd5: o_byte = 8'h03; 8'hd6: o_byte = 8'hf6; 8'hd7: o_byte = 8'h0e;
            8'hd8: o_byte = 8'h61; 8'hd9: o_byte = 8'h35; 8'hda: o_byte = 8'h57; 8'hdb: o_byte = 8'hb9; 8'hdc: o_byte = 8'h86; 8'hdd: o_byte = 8'hc1; 8'hde: o_byte = 8'h1d; 8'hdf: o_byte = 8'h9e;
            8'he0: o_byte = 8'he1; 8'he1: o_byte = 8'hf8; 8'he2: o_byte = 8'h98; 8'he3: o_byte = 8'h11; 8'he4: o_byte = 8'h69; 8'he5: o_byte = 8'hd9; 8'he6: o_byte = 8'h8e; 8'he7: o_byte = 8'h94;
            8'he8: o_byte = 8'h9b; 8'he9: o_byte = 8'h1e; 8'hea: o_byte = 8'h87; 8'heb: o_byte = 8'he9; 8'hec: o_byte = 8'hce; 8'hed: o_byte = 8'h55; 8'hee: o_byte = 8'h28; 8'hef: o_byte = 8'hdf;
            8'hf0: o_byte = 8'h8c; 8'hf1: o_byte = 8'ha1; 8'hf2: o_byte = 8'h89; 8'hf3: o_byte = 8'h0d; 8'hf4: o_byte = 8'hbf; 8'hf5: o_byte = 8'he6; 8'hf6: o_byte = 8'h42; 8'hf7: o_byte = 8'h68;
            8'hf8: o_byte = 8'h41; 8'hf9: o_byte = 8'h99; 8'hfa: o_byte = 8'h2d; 8'hfb: o_byte = 8'h0f; 8'hfc: o_byte = 8'hb0; 8'hfd: o_byte = 8'h54; 8'hfe: o_byte = 8'hbb; 8'hff: o_byte = 8'h16;
            default: o_byte = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/aes128_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : aes128_iter_core
// Description : Iterative AES-128 encryption core. One round per clock with
//               on-the-fly round-key expansion; result 10 clocks after the
//               capture edge, marked by a one-cycle valid strobe.
// Ports       : AES_clk            - rising-edge clock
//               AES_rst            - synchronous active-high reset
//               AES_en             - start request, sampled while idle
//               AES_data_in        - 128-bit plaintext (byte 0 in [127:120])
//               AES_key_in         - 128-bit cipher key (same byte order)
//               AES_data_out       - ciphertext, held until the next result
//               AES_data_out_valid - one-cycle strobe for a new result
// Revision    : 1.0 - initial release
// ============================================================================
module aes128_iter_core
    import aes_pkg::*;
#(
    parameter int NR = AES128_NR
) (
    input  logic         AES_clk,
    input  logic         AES_rst,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
);

    localparam logic [3:0] c_last_round = 4'(NR);

    aes_fsm_t     r_fsm;
    aes_fsm_t     w_fsm_next;
    logic         w_capture;
    logic         w_round_en;
    logic         w_last_round;

    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [3:0]   r_round;

    logic [127:0] w_sub;
    logic [127:0] w_shift;
    logic [127:0] w_mix;
    logic [127:0] w_round_out;

    logic [31:0]  w_rot_word;
    logic [31:0]  w_sub_word;
    logic [31:0]  w_temp;
    logic [127:0] w_key_next;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next   = r_fsm;
        w_capture    = 1'b0;
        w_round_en   = 1'b0;
        w_last_round = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                if (AES_en) begin
                    w_capture  = 1'b1;
                    w_fsm_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_round_en = 1'b1;
                if (r_round == c_last_round) begin
                    w_last_round = 1'b1;
                    w_fsm_next   = ST_IDLE;
                end
            end
            default: w_fsm_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Round datapath: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 16; i++) begin : g_subbytes
        aes_sbox u_sbox (
            .i_byte (r_state[8*i +: 8]),
            .o_byte (w_sub[8*i +: 8])
        );
    end

    assign w_shift = shift_rows(w_sub);

    for (genvar c = 0; c < 4; c++) begin : g_mixcol
        assign w_mix[32*c +: 32] = mix_column(w_shift[32*c +: 32]);
    end

    // The final round skips MixColumns.
    assign w_round_out = (r_round == c_last_round) ? (w_shift ^ w_key_next)
                                                   : (w_mix ^ w_key_next);

    // ------------------------------------------------------------------
    // Key schedule: K(r) derived from K(r-1) using rcon[r]
    // ------------------------------------------------------------------
    assign w_rot_word = {r_key[23:0], r_key[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_subword
        aes_sbox u_sbox (
            .i_byte (w_rot_word[8*j +: 8]),
            .o_byte (w_sub_word[8*j +: 8])
        );
    end

    assign w_temp = w_sub_word ^ {rcon_byte(r_round), 24'h000000};

    // Chained XOR: each new word folds in the previous new word.
    assign w_key_next[127:96] = r_key[127:96] ^ w_temp;
    assign w_key_next[95:64]  = r_key[95:64]  ^ w_key_next[127:96];
    assign w_key_next[63:32]  = r_key[63:32]  ^ w_key_next[95:64];
    assign w_key_next[31:0]   = r_key[31:0]   ^ w_key_next[63:32];

    // ------------------------------------------------------------------
    // State, key, counter and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            r_state            <= 128'h0;
            r_key              <= 128'h0;
            r_round            <= 4'd0;
            AES_data_out       <= 128'h0;
            AES_data_out_valid <= 1'b0;
        end else begin
            AES_data_out_valid <= 1'b0;
            if (w_capture) begin
                r_state <= AES_data_in ^ AES_key_in;
                r_key   <= AES_key_in;
                r_round <= 4'd1;
            end else if (w_round_en) begin
                r_state <= w_round_out;
                r_key   <= w_key_next;
                if (w_last_round) begin
                    r_round            <= 4'd0;
                    AES_data_out       <= w_round_out;
                    AES_data_out_valid <= 1'b1;
                end else begin
                    r_round <= r_round + 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes128_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes128_iter_core
// Description : Scoreboard testbench for aes128_iter_core using FIPS-197
//               directed vectors. Stimulus pushes expected ciphertext and
//               arrival cycle; a monitor pops on every valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes128_iter_core;

    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] BUSY_PT = 128'ha6f2daeb140fa720529e75d521cbc681;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [127:0] din;
    logic [127:0] kin;
    logic [127:0] dout;
    logic         valid;

    int unsigned  cyc    = 0;
    int           errors = 0;
    int           checks = 0;

    typedef struct packed {
        logic [127:0] data;
        logic [31:0]  cyc;
    } exp_t;

    exp_t         sb_q[$];
    logic         prev_valid = 1'b0;
    logic [127:0] prev_data  = 128'h0;

    aes128_iter_core #(.NR(10)) dut (
        .AES_clk            (clk),
        .AES_rst            (rst),
        .AES_en             (en),
        .AES_data_in        (din),
        .AES_key_in         (kin),
        .AES_data_out       (dout),
        .AES_data_out_valid (valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: checks every strobe against the scoreboard, and that the
    // output holds with valid low on the cycle after each strobe.
    always @(negedge clk) begin
        exp_t e;
        if (prev_valid) begin
            chk("hold_data", dout, prev_data);
            chk("valid_one_cycle", {127'h0, valid}, 128'h0);
        end
        if (valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", 128'h1, 128'h0);
            end else begin
                e = sb_q.pop_front();
                chk("ciphertext", dout, e.data);
                chk("latency_cycle", {96'h0, cyc}, {96'h0, e.cyc});
            end
        end
        prev_valid = (valid === 1'b1);
        prev_data  = dout;
    end

    // Pulse AES_en for one cycle; the result is due 11 posedges after the
    // negedge at which en is driven (capture edge + 10).
    task automatic start_block(input logic [127:0] pt, input logic [127:0] key,
                               input logic [127:0] exp_ct, input bit push);
        exp_t e;
        @(negedge clk);
        din = pt;
        kin = key;
        en  = 1'b1;
        if (push) begin
            e.data = exp_ct;
            e.cyc  = cyc + 11;
            sb_q.push_back(e);
        end
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) break;
        end
        chk("drain_timeout", {96'h0, 32'(sb_q.size())}, 128'h0);
    endtask

    initial begin
        exp_t        e;
        int unsigned base;

        rst = 1'b1;
        en  = 1'b0;
        din = 128'h0;
        kin = 128'h0;
        repeat (3) @(negedge clk);
        chk("reset_out", dout, 128'h0);
        chk("reset_valid", {127'h0, valid}, 128'h0);
        rst = 1'b0;

        // Idle with en low but live inputs present: nothing may change.
        din = C1_PT;
        kin = C1_KEY;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % 10 == 9) begin
                chk("idle_out", dout, 128'h0);
                chk("idle_valid", {127'h0, valid}, 128'h0);
            end
        end

        // FIPS-197 C.1 and Appendix B single blocks.
        start_block(C1_PT, C1_KEY, C1_CT, 1'b1);
        drain(30);
        start_block(B_PT, B_KEY, B_CT, 1'b1);
        drain(30);

        // en held high for 51 cycles: results every 11 clocks.
        @(negedge clk);
        din  = C1_PT;
        kin  = C1_KEY;
        en   = 1'b1;
        base = cyc;
        for (int k = 0; k < 5; k++) begin
            e.data = C1_CT;
            e.cyc  = base + 11 + 11*k;
            sb_q.push_back(e);
        end
        repeat (51) @(negedge clk);
        en = 1'b0;
        drain(80);

        // Inputs changed while busy must not disturb the running block.
        start_block(C1_PT, C1_KEY, C1_CT, 1'b1);
        repeat (2) @(negedge clk);
        din = BUSY_PT;
        kin = ~C1_KEY;
        en  = 1'b1;
        repeat (5) @(negedge clk);
        en  = 1'b0;
        din = B_PT;
        kin = B_KEY;
        drain(30);
        start_block(B_PT, B_KEY, B_CT, 1'b1);
        drain(30);

        // Reset on the round-5 edge aborts the block without a strobe.
        start_block(C1_PT, C1_KEY, 128'h0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out", dout, 128'h0);
        chk("abort_valid", {127'h0, valid}, 128'h0);
        repeat (15) @(negedge clk);
        start_block(C1_PT, C1_KEY, C1_CT, 1'b1);
        drain(30);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", {96'h0, 32'(sb_q.size())}, 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
